axi_slave_mem: RTL and testbench

Word-addressed AXI4 memory slave (no ID signals) that terminates the slave side of the team's AXI interface. It consumes AW/W bursts and returns B responses, and serves AR bursts with R beats. It supports FIXED, INCR and optionally WRAP bursts. The write and read channels run as independent state machines over one shared storage array, and the block is the downstream endpoint for the AXI master driver and testbench.

---
 rtl/axi_mem_pkg.sv | 29 ++
 rtl/axi_slave_mem_if.sv | 51 +++++
 rtl/axi_burst_addr.sv | 47 ++++
 rtl/axi_slave_mem.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state types and burst context for the axi_slave_mem block.
package axi_mem_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned RESP_W     = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Burst attributes latched at the address handshake
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } burst_ctx_t;

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 (no ID) bus between a master and the axi_slave_mem endpoint.
interface axi_slave_mem_if;
  import axi_mem_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]      awlen;
  logic [SIZE_W-1:0]     awsize;
  logic [BURST_W-1:0]    awburst;
  logic                  awvalid;
  logic                  awready;

  logic [AXI_DATA_W-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [RESP_W-1:0]     bresp;
  logic                  bvalid;
  logic                  bready;

  logic [AXI_ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]      arlen;
  logic [SIZE_W-1:0]     arsize;
  logic [BURST_W-1:0]    arburst;
  logic                  arvalid;
  logic                  arready;

  logic [AXI_DATA_W-1:0] rdata;
  logic [RESP_W-1:0]     rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Next-beat address and burst legality for one AXI channel.
// WRAP support is enabled by defining AXI_MEM_WRAP_EN; otherwise WRAP is illegal.
module axi_burst_addr
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr,
  output logic               illegal
);

  logic [ADDR_W-1:0] step;
  assign step = ADDR_W'(1) << size;

`ifdef AXI_MEM_WRAP_EN
  // Wrap boundary is (len+1) beats of 1<<size bytes, always a power of two when legal
  logic [ADDR_W-1:0] wrap_mask;
  logic              len_ok;
  assign wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
  assign len_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  always_comb begin
    next_addr = addr;
    illegal   = (size > 3'd2) || (burst == 2'b11);
    case (burst)
      BURST_INCR: next_addr = addr + step;
`ifdef AXI_MEM_WRAP_EN
      BURST_WRAP: begin
        next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
        if (!len_ok) illegal = 1'b1;
      end
`else
      BURST_WRAP: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// Word-addressed AXI4 memory slave with independent write and read FSMs over one array.
// Optional WRAP burst support: define AXI_MEM_WRAP_EN.
module axi_slave_mem
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_slave_mem_if.slave   s
);

  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned WORD_W = ADDR_W - 2;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // ---------------- write channel ----------------
  w_state_e           w_state, w_state_n;
  logic [ADDR_W-1:0]  w_addr, w_addr_n, w_next;
  burst_ctx_t         w_ctx, w_ctx_n;
  logic [LEN_W-1:0]   w_cnt, w_cnt_n;
  logic               w_err, w_err_n, w_illegal, w_oor, w_last_beat, mem_we_c;
  logic               awready_q, awready_n, wready_q, wready_n, bvalid_q, bvalid_n;
  logic [RESP_W-1:0]  bresp_q, bresp_n;

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
    .addr(w_addr), .len(w_ctx.len), .size(w_ctx.size), .burst(w_ctx.burst),
    .next_addr(w_next), .illegal(w_illegal)
  );

  assign w_oor       = w_addr[ADDR_W-1:2] >= WORD_W'(MEM_DEPTH);
  assign w_last_beat = (w_cnt == w_ctx.len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      w_addr    <= '0;
      w_ctx     <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_state_n;
      w_addr    <= w_addr_n;
      w_ctx     <= w_ctx_n;
      w_cnt     <= w_cnt_n;
      w_err     <= w_err_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
    end
  end

  always_comb begin
    w_state_n = w_state;
    w_addr_n  = w_addr;
    w_ctx_n   = w_ctx;
    w_cnt_n   = w_cnt;
    w_err_n   = w_err;
    awready_n = awready_q;
    wready_n  = wready_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    mem_we_c  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_n = 1'b1;
        if (s.awvalid && awready_q) begin
          w_addr_n  = ADDR_W'(s.awaddr);
          w_ctx_n   = '{len: s.awlen, size: s.awsize, burst: s.awburst};
          w_cnt_n   = '0;
          w_err_n   = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b1;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (s.wvalid && wready_q) begin
          // Error is sticky; out-of-range beats are dropped, illegal bursts write nothing
          mem_we_c = !w_illegal && !w_oor;
          w_err_n  = w_err | w_illegal | w_oor | (s.wlast != w_last_beat);
          w_addr_n = w_next;
          w_cnt_n  = w_cnt + 8'd1;
          if (w_last_beat) begin
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = w_err_n ? RESP_SLVERR : RESP_OKAY;
            w_state_n = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s.bready) begin
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OKAY;
          awready_n = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Byte-lane writes; storage has no reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s.wstrb[b]) mem[w_addr[IDX_W+1:2]][8*b +: 8] <= s.wdata[8*b +: 8];
      end
    end
  end

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;

  // ---------------- read channel ----------------
  r_state_e           r_state, r_state_n;
  logic [ADDR_W-1:0]  r_addr, r_addr_n, r_look_addr, r_next;
  burst_ctx_t         r_ctx, r_ctx_n, r_look_ctx;
  logic [LEN_W-1:0]   r_cnt, r_cnt_n;
  logic               r_illegal, fetch_bad;
  logic [WORD_W-1:0]  fetch_word;
  logic [DATA_W-1:0]  fetch_data;
  logic               arready_q, arready_n, rvalid_q, rvalid_n, rlast_q, rlast_n;
  logic [DATA_W-1:0]  rdata_q, rdata_n;
  logic [RESP_W-1:0]  rresp_q, rresp_n;

  // In idle the calculator sees the incoming AR payload, otherwise the latched burst
  always_comb begin
    r_look_addr = r_addr;
    r_look_ctx  = r_ctx;
    if (r_state == R_IDLE) begin
      r_look_addr = ADDR_W'(s.araddr);
      r_look_ctx  = '{len: s.arlen, size: s.arsize, burst: s.arburst};
    end
  end

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
    .addr(r_look_addr), .len(r_look_ctx.len), .size(r_look_ctx.size), .burst(r_look_ctx.burst),
    .next_addr(r_next), .illegal(r_illegal)
  );

  assign fetch_word = (r_state == R_IDLE) ? r_look_addr[ADDR_W-1:2] : r_next[ADDR_W-1:2];
  assign fetch_bad  = r_illegal || (fetch_word >= WORD_W'(MEM_DEPTH));
  assign fetch_data = fetch_bad ? '0 : mem[fetch_word[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_ctx     <= '0;
      r_cnt     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state   <= r_state_n;
      r_addr    <= r_addr_n;
      r_ctx     <= r_ctx_n;
      r_cnt     <= r_cnt_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rlast_q   <= rlast_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
    end
  end

  always_comb begin
    r_state_n = r_state;
    r_addr_n  = r_addr;
    r_ctx_n   = r_ctx;
    r_cnt_n   = r_cnt;
    arready_n = arready_q;
    rvalid_n  = rvalid_q;
    rlast_n   = rlast_q;
    rdata_n   = rdata_q;
    rresp_n   = rresp_q;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (s.arvalid && arready_q) begin
          r_addr_n  = r_look_addr;
          r_ctx_n   = r_look_ctx;
          r_cnt_n   = '0;
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = fetch_data;
          rresp_n   = fetch_bad ? RESP_SLVERR : RESP_OKAY;
          rlast_n   = (s.arlen == 8'd0);
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s.rready) begin
          if (r_cnt == r_ctx.len) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            rdata_n   = '0;
            rresp_n   = RESP_OKAY;
            arready_n = 1'b1;
            r_state_n = R_IDLE;
          end else begin
            r_addr_n = r_next;
            r_cnt_n  = r_cnt + 8'd1;
            rdata_n  = fetch_data;
            rresp_n  = fetch_bad ? RESP_SLVERR : RESP_OKAY;
            rlast_n  = (r_cnt_n == r_ctx.len);
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rlast   = rlast_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem with a transaction-level memory model.
module tb_axi_slave_mem;

  localparam int MEM_DEPTH = 1024;

  logic clk;
  logic rst_n;
  axi_slave_mem_if bus();

  axi_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [31:0] m_mem [MEM_DEPTH];
  logic [34:0] exp_r [$];   // {rdata, rresp, rlast}
  logic [1:0]  exp_b [$];
  logic [31:0] wd [16];
  logic [31:0] got [$];
  logic [1:0]  last_rresp;
  logic        last_rlast;
  logic [1:0]  last_bresp;
  int          last_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    failed++;
    $display("FAIL %s: handshake not seen within cycle bound", name);
  endtask

  // ---------------- model ----------------
  function automatic bit m_legal(input int len, input int size, input int burst);
    if (size > 2 || burst == 3) return 1'b0;
    if (burst == 2) begin
`ifdef AXI_MEM_WRAP_EN
      return (len == 1 || len == 3 || len == 7 || len == 15);
`else
      return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input int len, input int size, input int burst);
    logic [31:0] step, w, lo;
    step = 32'(1) << size;
    w    = 32'(len + 1) * step;
    case (burst)
      1: return a + step;
      2: begin
        lo = (a / w) * w;
        return lo + ((a - lo + step) % w);
      end
      default: return a;
    endcase
  endfunction

  task automatic m_write(input logic [31:0] addr, input int len, input int size, input int burst,
                         input logic [3:0] strb, input int last_beat, output logic [1:0] resp);
    logic [31:0] a;
    bit legal, err;
    a = addr;
    legal = m_legal(len, size, burst);
    err = !legal || (last_beat != len);
    for (int i = 0; i <= len; i++) begin
      if (a / 4 >= MEM_DEPTH) err = 1'b1;
      else if (legal)
        for (int b = 0; b < 4; b++) if (strb[b]) m_mem[a/4][8*b +: 8] = wd[i][8*b +: 8];
      a = m_next(a, len, size, burst);
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic m_read(input logic [31:0] addr, input int len, input int size, input int burst);
    logic [31:0] a;
    bit legal;
    a = addr;
    legal = m_legal(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      if (legal && a / 4 < MEM_DEPTH) exp_r.push_back({m_mem[a/4], 2'b00, i == len});
      else exp_r.push_back({32'd0, 2'b10, i == len});
      a = m_next(a, len, size, burst);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rvalid) begin
        if (exp_r.size() == 0) begin
          tests++; failed++;
          $display("FAIL r_unexpected: rvalid with rdata %h but no beat expected", bus.rdata);
        end else begin
          check("r_beat", 64'({bus.rdata, bus.rresp, bus.rlast}), 64'(exp_r[0]));
          if (bus.rready) void'(exp_r.pop_front());
        end
      end
      if (bus.bvalid) begin
        if (exp_b.size() == 0) begin
          tests++; failed++;
          $display("FAIL b_unexpected: bvalid with bresp %h but no response expected", bus.bresp);
        end else begin
          check("b_resp", 64'(bus.bresp), 64'(exp_b[0]));
          if (bus.bready) void'(exp_b.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_write(input logic [31:0] addr, input int len, input int size, input int burst,
                          input logic [3:0] strb, input int last_beat, input int bready_delay);
    logic [1:0] er;
    bit hs;
    int n;
    m_write(addr, len, size, burst, strb, last_beat, er);
    exp_b.push_back(er);
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = 3'(size); bus.awburst = 2'(burst);
    bus.awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); hs = bus.awready; @(posedge clk); #1; n++; end while (!hs && n < 50);
    bus.awvalid = 1'b0;
    if (!hs) begin timeout("aw_handshake"); return; end
    check("wready_after_aw", 64'(bus.wready), 64'(1));
    check("awready_busy", 64'(bus.awready), 64'(0));
    for (int i = 0; i <= len; i++) begin
      bus.wdata = wd[i]; bus.wstrb = strb; bus.wlast = (i == last_beat); bus.wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); hs = bus.wready; @(posedge clk); #1; n++; end while (!hs && n < 50);
      if (!hs) begin bus.wvalid = 1'b0; timeout("w_handshake"); return; end
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_after_last_w", 64'(bus.bvalid), 64'(1));
    for (int d = 0; d < bready_delay; d++) begin
      @(negedge clk);
      check("bp_bvalid", 64'(bus.bvalid), 64'(1));
      check("bp_bresp", 64'(bus.bresp), 64'(er));
      check("bp_awready", 64'(bus.awready), 64'(0));
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    n = 0;
    do begin @(negedge clk); hs = bus.bvalid; last_bresp = bus.bresp; @(posedge clk); #1; n++; end
    while (!hs && n < 50);
    bus.bready = 1'b0;
    if (!hs) begin timeout("b_handshake"); return; end
    check("awready_after_b", 64'(bus.awready), 64'(1));
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int size, input int burst,
                         input bit toggle);
    bit hs;
    int n, cyc;
    got.delete();
    m_read(addr, len, size, burst);
    bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = 3'(size); bus.arburst = 2'(burst);
    bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); hs = bus.arready; @(posedge clk); #1; n++; end while (!hs && n < 50);
    bus.arvalid = 1'b0;
    if (!hs) begin timeout("ar_handshake"); return; end
    check("rvalid_after_ar", 64'(bus.rvalid), 64'(1));
    check("arready_busy", 64'(bus.arready), 64'(0));
    cyc = 0;
    while (got.size() < len + 1 && cyc < 100) begin
      bus.rready = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      if (bus.rvalid && bus.rready) begin
        got.push_back(bus.rdata); last_rresp = bus.rresp; last_rlast = bus.rlast;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    last_cycles = cyc;
    if (got.size() != len + 1) begin timeout("r_beats"); return; end
    check("rvalid_done", 64'(bus.rvalid), 64'(0));
    check("arready_after_r", 64'(bus.arready), 64'(1));
  endtask

  task automatic expect_words(input string name, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input int cnt);
    logic [31:0] e [4];
    e[0] = w0; e[1] = w1; e[2] = w2; e[3] = w3;
    for (int i = 0; i < cnt; i++) begin
      if (i < got.size()) check(name, 64'(got[i]), 64'(e[i]));
      else begin tests++; failed++; $display("FAIL %s: beat %0d missing, need %h", name, i, e[i]); end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_awready"}, 64'(bus.awready), 64'(0));
    check({name, "_arready"}, 64'(bus.arready), 64'(0));
    check({name, "_wready"},  64'(bus.wready),  64'(0));
    check({name, "_bvalid"},  64'({bus.bvalid, bus.bresp}), 64'(0));
    check({name, "_rout"},    64'({bus.rvalid, bus.rlast, bus.rresp, bus.rdata}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("awready_pre_edge", 64'(bus.awready), 64'(0));
    @(posedge clk); #1;
    check("awready_first_edge", 64'(bus.awready), 64'(1));
    check("arready_first_edge", 64'(bus.arready), 64'(1));

    // single beat
    wd[0] = 32'hDEADBEEF;
    do_write(32'h10, 0, 2, 1, 4'hF, 0, 0);
    check("single_bresp", 64'(last_bresp), 64'(0));
    do_read(32'h10, 0, 2, 1, 1'b0);
    expect_words("single_rdata", 32'hDEADBEEF, 0, 0, 0, 1);
    check("single_rlast_rresp", 64'({last_rlast, last_rresp}), 64'(3'b100));

    // INCR 4-beat, no bubbles with rready high
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    do_write(32'h100, 3, 2, 1, 4'hF, 3, 0);
    do_read(32'h100, 3, 2, 1, 1'b0);
    expect_words("incr_rdata", 1, 2, 3, 4, 4);
    check("incr_no_bubble", 64'(last_cycles), 64'(4));

    // rready toggling
    do_read(32'h100, 3, 2, 1, 1'b1);
    expect_words("toggle_rdata", 1, 2, 3, 4, 4);

    // WRAP len=3 at 0x18 over a prefilled 0x10..0x1C
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    do_write(32'h10, 3, 2, 1, 4'hF, 3, 0);
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    do_write(32'h18, 3, 2, 2, 4'hF, 3, 0);
    do_read(32'h10, 3, 2, 1, 1'b0);
`ifdef AXI_MEM_WRAP_EN
    check("wrap_bresp", 64'(last_bresp), 64'(0));
    expect_words("wrap_mem", 32'hC, 32'hD, 32'hA, 32'hB, 4);
`else
    check("wrap_bresp", 64'(last_bresp), 64'(2));
    expect_words("wrap_mem", 32'h11, 32'h22, 32'h33, 32'h44, 4);
`endif
    do_read(32'h18, 3, 2, 2, 1'b0);
`ifdef AXI_MEM_WRAP_EN
    expect_words("wrap_read", 32'hA, 32'hB, 32'hC, 32'hD, 4);
`else
    expect_words("wrap_read", 0, 0, 0, 0, 4);
    check("wrap_read_rresp", 64'(last_rresp), 64'(2));
`endif

    // FIXED: all beats hit one word
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    do_write(32'h50, 2, 2, 0, 4'hF, 2, 0);
    do_read(32'h50, 1, 2, 0, 1'b0);
    expect_words("fixed_rdata", 3, 3, 0, 0, 2);

    // Out of range at the last word
    wd[0] = 32'h5; wd[1] = 32'h6;
    do_write(32'hFFC, 1, 2, 1, 4'hF, 1, 0);
    check("oor_bresp", 64'(last_bresp), 64'(2));
    do_read(32'hFFC, 1, 2, 1, 1'b0);
    expect_words("oor_rdata", 5, 0, 0, 0, 2);
    check("oor_rresp", 64'(last_rresp), 64'(2));

    // B backpressure
    wd[0] = 32'h77;
    do_write(32'h200, 0, 2, 1, 4'hF, 0, 5);
    check("bp_final_bresp", 64'(last_bresp), 64'(0));

    // Partial strobes
    wd[0] = 32'hFFFFFFFF;
    do_write(32'h40, 0, 2, 1, 4'hF, 0, 0);
    wd[0] = 32'h00001234;
    do_write(32'h40, 0, 2, 1, 4'b0011, 0, 0);
    do_read(32'h40, 0, 2, 1, 1'b0);
    expect_words("partial_rdata", 32'hFFFF1234, 0, 0, 0, 1);

    // Early wlast: beats still written, SLVERR
    wd[0] = 32'h9; wd[1] = 32'h10;
    do_write(32'h80, 1, 2, 1, 4'hF, 0, 0);
    check("wlast_bresp", 64'(last_bresp), 64'(2));
    do_read(32'h80, 1, 2, 1, 1'b0);
    expect_words("wlast_rdata", 32'h9, 32'h10, 0, 0, 2);

    // Illegal size writes nothing
    wd[0] = 32'h55;
    do_write(32'h300, 0, 2, 1, 4'hF, 0, 0);
    wd[0] = 32'h99;
    do_write(32'h300, 0, 3, 1, 4'hF, 0, 0);
    check("size_bresp", 64'(last_bresp), 64'(2));
    do_read(32'h300, 0, 2, 1, 1'b0);
    expect_words("size_rdata", 32'h55, 0, 0, 0, 1);

    // Reset during beat 2 of a 4-beat read
    m_read(32'h100, 3, 2, 1);
    bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arburst = 2'd1; bus.arvalid = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    bus.rready = 1'b0;
    check("mid_beat2_valid", 64'(bus.rvalid), 64'(1));
    check("mid_beat2_data", 64'(bus.rdata), 64'(2));
    rst_n = 1'b0;
    exp_r.delete();
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_arready_pre", 64'(bus.arready), 64'(0));
    @(posedge clk); #1;
    check("mid_arready_edge", 64'(bus.arready), 64'(1));
    do_read(32'h100, 3, 2, 1, 1'b0);
    expect_words("after_reset_rdata", 1, 2, 3, 4, 4);

    repeat (3) @(posedge clk);
    check("exp_r_drained", 64'(exp_r.size()), 64'(0));
    check("exp_b_drained", 64'(exp_b.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
